// File: rtl/unified_memory.sv
// unified_memory: single-clock word memory shared by a CPU data port (valid/ready,
// byte enables), a DMA full-word write port and an instruction fetch port.
// Latency: 1 cycle for data reads, fetches and writes; the array has synchronous read.
// Backpressure: DMA wins by default; after STARVE_LIMIT stalled data cycles the data port wins one cycle.
// Ports: clock/reset; req_* data port with resp_* read return; dma_* write port;
//        instr_address/instr fetch port; addr_error sticky out-of-range flag.
module unified_memory #(
    parameter int                    WORD_NUM     = 2048,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(32'h21000000),
    parameter int                    STARVE_LIMIT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_address,
    input  logic [DATA_WIDTH-1:0]     req_write_data,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_enable,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    input  logic                      dma_valid,
    output logic                      dma_ready,
    input  logic [ADDR_WIDTH-1:0]     dma_address,
    input  logic [DATA_WIDTH-1:0]     dma_data,
    input  logic [ADDR_WIDTH-1:0]     instr_address,
    output logic [DATA_WIDTH-1:0]     instr,
    output logic                      addr_error
);

    localparam int                    IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam int                    BYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LP_WORDS = ADDR_WIDTH'(WORD_NUM);
    localparam logic [7:0]            LP_LIMIT = 8'(STARVE_LIMIT);

    logic [DATA_WIDTH-1:0] r_mem [WORD_NUM];
    logic [7:0]            r_starve;

    logic                  w_starved;
    logic                  w_req_acc;
    logic                  w_dma_acc;
    logic                  w_req_in;
    logic                  w_dma_in;
    logic                  w_instr_in;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_dat;
    logic [BYTES-1:0]      w_wr_be;

    // Range checks use the full address so stray high bits never alias into the array.
    assign w_req_in   = (req_address   < LP_WORDS);
    assign w_dma_in   = (dma_address   < LP_WORDS);
    assign w_instr_in = (instr_address < LP_WORDS);

    // Readies depend only on dma_valid and the starvation count, never on req_valid,
    // so the two ports can never be accepted in the same cycle.
    assign w_starved = (r_starve >= LP_LIMIT);
    assign req_ready = !reset && (w_starved || !dma_valid);
    assign dma_ready = !reset && !w_starved;
    assign w_req_acc = req_valid && req_ready;
    assign w_dma_acc = dma_valid && dma_ready;

    // Single shared write port: DMA writes the whole word, the data port uses its byte mask.
    assign w_wr_en  = (w_req_acc && req_write && w_req_in) || (w_dma_acc && w_dma_in);
    assign w_wr_idx = w_dma_acc ? dma_address[IDX_W-1:0] : req_address[IDX_W-1:0];
    assign w_wr_dat = w_dma_acc ? dma_data : req_write_data;
    assign w_wr_be  = w_dma_acc ? {BYTES{1'b1}} : req_byte_enable;

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        for (int b = 0; b < BYTES; b++) begin
            if (w_wr_en && w_wr_be[b]) begin
                r_mem[w_wr_idx][8*b +: 8] <= w_wr_dat[8*b +: 8];
            end
        end
    end

    // Saturating so a pathological stall cannot wrap back below the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= 8'd0;
        end else if (!req_valid || w_req_acc) begin
            r_starve <= 8'd0;
        end else if (r_starve != 8'hFF) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    // Data read return; reads sample the array before this edge's write (read-first).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= w_req_acc && !req_write;
            if (w_req_acc && !req_write) begin
                resp_data <= w_req_in ? r_mem[req_address[IDX_W-1:0]] : '0;
            end
        end
    end

    // Fetch port, also read-first against a same-cycle write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr <= NOP_WORD;
        end else begin
            instr <= w_instr_in ? r_mem[instr_address[IDX_W-1:0]] : NOP_WORD;
        end
    end

    // Sticky; out-of-range fetches are deliberately excluded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_error <= 1'b0;
        end else if ((w_req_acc && !w_req_in) || (w_dma_acc && !w_dma_in)) begin
            addr_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unified_memory.sv
module tb_unified_memory;

    localparam logic [31:0] NOP = 32'h21000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_address, req_write_data;
    logic [3:0]  req_byte_enable;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        dma_valid, dma_ready;
    logic [31:0] dma_address, dma_data;
    logic [31:0] instr_address;
    logic [31:0] instr;
    logic        addr_error;

    int n_checks = 0;
    int n_errors = 0;

    unified_memory #(
        .WORD_NUM(2048), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .NOP_WORD(32'h21000000), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_byte_enable(req_byte_enable),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .dma_valid(dma_valid), .dma_ready(dma_ready),
        .dma_address(dma_address), .dma_data(dma_data),
        .instr_address(instr_address), .instr(instr),
        .addr_error(addr_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rv;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dd;
        logic [31:0] ia;
        logic        erv;
        logic [31:0] erd;
        logic        chk_i;
        logic [31:0] ei;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [31:0] ia);
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_address     = 32'd0;
        req_write_data  = 32'd0;
        req_byte_enable = 4'd0;
        dma_valid       = 1'b0;
        dma_address     = 32'd0;
        dma_data        = 32'd0;
        instr_address   = ia;
    endtask

    task automatic dreq(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid       = 1'b1;
        req_write       = wr;
        req_address     = a;
        req_write_data  = d;
        req_byte_enable = be;
    endtask

    task automatic dma(input logic [31:0] a, input logic [31:0] d);
        dma_valid   = 1'b1;
        dma_address = a;
        dma_data    = d;
    endtask

    initial begin
        //            rv  wr  addr   wdata         be      dv  daddr  ddata         iaddr  erv  erd           chk_i ei
        tbl[0]  = '{1'b1,1'b1,32'd5, 32'hDEADBEEF,4'b1111,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'h0,       1'b1,NOP};
        tbl[1]  = '{1'b1,1'b0,32'd5, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b1,32'hDEADBEEF,1'b1,NOP};
        tbl[2]  = '{1'b1,1'b1,32'd5, 32'h000000AA,4'b0001,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'hDEADBEEF,1'b1,NOP};
        tbl[3]  = '{1'b1,1'b0,32'd5, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b1,32'hDEADBEAA,1'b1,NOP};
        tbl[4]  = '{1'b1,1'b1,32'd5, 32'hFFFFFFFF,4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'hDEADBEAA,1'b1,NOP};
        tbl[5]  = '{1'b1,1'b0,32'd5, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b1,32'hDEADBEAA,1'b1,NOP};
        tbl[6]  = '{1'b1,1'b1,32'd6, 32'h0,       4'b1111,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'hDEADBEAA,1'b1,NOP};
        tbl[7]  = '{1'b1,1'b1,32'd6, 32'h11223344,4'b1010,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'hDEADBEAA,1'b1,NOP};
        tbl[8]  = '{1'b1,1'b0,32'd6, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd5,   1'b1,32'h11003300,1'b1,32'hDEADBEAA};
        tbl[9]  = '{1'b0,1'b0,32'd0, 32'h0,       4'b0000,1'b1,32'd9, 32'hCAFEF00D, 32'd6,   1'b0,32'h11003300,1'b1,32'h11003300};
        tbl[10] = '{1'b1,1'b0,32'd9, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd9,   1'b1,32'hCAFEF00D,1'b1,32'hCAFEF00D};
        tbl[11] = '{1'b1,1'b0,32'd5, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b1,32'hDEADBEAA,1'b1,NOP};
        tbl[12] = '{1'b0,1'b0,32'd0, 32'h0,       4'b0000,1'b0,32'd0, 32'd0,        32'd3000,1'b0,32'hDEADBEAA,1'b1,NOP};

        // Reset state
        idle(32'd3000);
        reset = 1'b1;
        tick();
        tick();
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_addr_error", {31'd0, addr_error}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_dma_ready", {31'd0, dma_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_dma_ready", {31'd0, dma_ready}, 32'd1);
        tick();

        // Directed vector table, one transaction per cycle
        for (int i = 0; i < 13; i++) begin
            req_valid       = tbl[i].rv;
            req_write       = tbl[i].wr;
            req_address     = tbl[i].addr;
            req_write_data  = tbl[i].wd;
            req_byte_enable = tbl[i].be;
            dma_valid       = tbl[i].dv;
            dma_address     = tbl[i].da;
            dma_data        = tbl[i].dd;
            instr_address   = tbl[i].ia;
            #1;
            chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, {31'd0, !tbl[i].dv});
            chk($sformatf("v%0d_dma_ready", i), {31'd0, dma_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, {31'd0, tbl[i].erv});
            chk($sformatf("v%0d_resp_data", i), resp_data, tbl[i].erd);
            if (tbl[i].chk_i) chk($sformatf("v%0d_instr", i), instr, tbl[i].ei);
            chk($sformatf("v%0d_addr_error", i), {31'd0, addr_error}, 32'd0);
        end

        // Starvation: 4 DMA accepts then one data accept, repeating
        idle(32'd3000);
        dreq(1'b0, 32'd5, 32'd0, 4'd0);
        for (int c = 0; c < 10; c++) begin
            dma(32'd20, 32'(c));
            #1;
            chk($sformatf("starve%0d_req_ready", c), {31'd0, req_ready}, {31'd0, (c % 5) == 4});
            chk($sformatf("starve%0d_dma_ready", c), {31'd0, dma_ready}, {31'd0, (c % 5) != 4});
            tick();
            chk($sformatf("starve%0d_resp_valid", c), {31'd0, resp_valid}, {31'd0, (c % 5) == 4});
            if ((c % 5) == 4) chk($sformatf("starve%0d_resp_data", c), resp_data, 32'hDEADBEAA);
        end

        // Dropping req_valid clears the partial starvation count
        tick();
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("restart%0d_req_ready", k), {31'd0, req_ready}, {31'd0, k == 4});
            tick();
        end

        // Out-of-range accesses
        idle(32'd3000);
        #1;
        chk("pre_oor_addr_error", {31'd0, addr_error}, 32'd0);
        dreq(1'b0, 32'd2048, 32'd0, 4'd0);
        tick();
        chk("oor_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("oor_resp_data", resp_data, 32'd0);
        chk("oor_addr_error", {31'd0, addr_error}, 32'd1);
        dreq(1'b1, 32'd2053, 32'h0, 4'b1111);
        tick();
        idle(32'd3000);
        dma(32'h80000005, 32'h0);
        tick();
        idle(32'd3000);
        dreq(1'b0, 32'd5, 32'd0, 4'd0);
        tick();
        chk("alias_resp_data", resp_data, 32'hDEADBEAA);
        chk("oor_fetch_instr", instr, NOP);

        // Same-cycle DMA write and fetch of one address: read-first
        idle(32'd3000);
        dma(32'd7, 32'h0BADF00D);
        tick();
        idle(32'd7);
        dma(32'd7, 32'h12345678);
        tick();
        chk("rf_old_instr", instr, 32'h0BADF00D);
        idle(32'd7);
        tick();
        chk("rf_new_instr", instr, 32'h12345678);

        // Reset right after a read accept drops the response
        dreq(1'b0, 32'd5, 32'd0, 4'd0);
        tick();
        reset = 1'b1;
        idle(32'd7);
        #1;
        chk("rstf_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("rstf_hold_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstf_instr", instr, NOP);
        chk("rstf_addr_error", {31'd0, addr_error}, 32'd0);
        chk("rstf_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_rst_addr_error", {31'd0, addr_error}, 32'd0);
        chk("post_rst_instr", instr, 32'h12345678);

        // DMA out-of-range sets the flag as well
        dma(32'd2048, 32'hFFFFFFFF);
        tick();
        chk("dma_oor_addr_error", {31'd0, addr_error}, 32'd1);
        idle(32'd3000);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
